pshare_predictor: RTL and testbench
===================================

# pshare_predictor

Parametrised local-history (pshare) branch direction and target predictor, the successor to the fixed 100-entry pshare model. It sits beside the fetch stage. A lookup port returns a registered direction and target prediction for a PC. A separate resolve port trains the per-PC history, the saturating counter table and the target table. It also keeps wrap-around branch and misprediction statistics.

## Interface
- ADDR_W, 32, PC / target width.
- BHT_BITS, 4, log2 entries of local history table and target table.
- HIST_W, 4, local history length; PHT has 2^HIST_W counters.
- CTR_W, 2, saturating counter width (>=2).
- CNT_W, 32, statistics counter width.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- lookup_valid  in  1  lookup request this cycle.
- lookup_pc  in  ADDR_W  PC to predict.
- pred_valid  out  1  prediction valid (1 cycle after lookup_valid).
- pred_taken  out  1  predicted direction.
- pred_target  out  ADDR_W  predicted next PC.
- upd_valid  in  1  resolved branch this cycle.
- upd_pc  in  ADDR_W  PC of resolved branch.
- upd_taken  in  1  actual direction.
- upd_target  in  ADDR_W  actual taken target.
- upd_pred_taken  in  1  direction that was predicted for this branch.
- total_branch  out  CNT_W  resolved branches since reset.
- mispredicts  out  CNT_W  direction mispredictions since reset.

## Operation
- bht_idx = pc[BHT_BITS+1:2]; pht_idx = pc[HIST_W+1:2] XOR bht[bht_idx].
- Counter reset value: 2^(CTR_W-1)-1 (weakly not-taken; 2'b01 for CTR_W=2). Histories, target valid bits, targets, statistics and all outputs reset to 0.
- Lookup: pred_taken = PHT[pht_idx] MSB; pred_target = upd-trained target if pred_taken and tgt_valid[bht_idx], else lookup_pc+4 (mod 2^ADDR_W).
- Update, on upd_valid:
  - pht_idx is computed from upd_pc and the pre-update history.
  - The counter increments if taken and decrements otherwise. It saturates at all-ones and at 0.
  - The new history is {history[HIST_W-2:0], upd_taken}.
  - If taken, the target is written and tgt_valid is set. A not-taken update leaves the target untouched.
- Statistics:
  - total_branch increments on every upd_valid.
  - mispredicts increments when upd_taken != upd_pred_taken.
  - Both wrap at 2^CNT_W.
- Simultaneous lookup and update of the same entries: the lookup sees pre-update state (no bypass).
- Aliasing between PCs sharing bht_idx/pht_idx is accepted; there are no tags.

## Timing
- Lookup latency 1: pred_* are registered at the edge sampling lookup_valid. pred_valid is low in cycles following no lookup; pred_taken/pred_target hold their last value.
- Update write takes effect at the sampling edge. A lookup in the next cycle observes it.
- reset low asserts asynchronously: outputs, tables and counters clear immediately, mid-operation included. The first lookup is accepted on the first rising edge after reset is released.
- No back-pressure: one lookup and one update per cycle, always accepted.

## Structure
- Package pshare_pkg holds:
  - The counter state encodings SN/WN/WT/ST for CTR_W=2.
  - The counter reset-value constant.
  - A saturating increment/decrement function.
  - The index functions.
- One sub-module, pshare_ctr_array, holds the 2^HIST_W x CTR_W counter array with one read port and one read-modify-write update port, plus async reset. History and target tables stay in the top.

## Test plan
- Reset, then lookup 0x100 -> next cycle pred_valid=1, pred_taken=0, pred_target=0x104, total_branch=0, mispredicts=0.
- Five taken updates on pc 0x40, target 0x80 -> indices 0,1,3,7,F trained and history=4'b1111. A lookup of 0x40 then gives pred_taken=1, pred_target=0x80.
- Saturation: three further taken updates on 0x40 leave PHT[F]=2'b11. One not-taken update gives PHT[F]=2'b10 and history 4'b1110. A lookup of 0x40 (index E, untrained) then gives pred_taken=0, pred_target=0x80 not used (0x44).
- Statistics: update with upd_pred_taken=1, upd_taken=0 -> total_branch+1, mispredicts+1. A matching update -> total_branch+1 only. Preloading at 2^CNT_W-1 (CNT_W=4 build) wraps to 0.
- Same-cycle lookup and first taken update of pc 0x40 from reset -> pred_taken=0. A lookup of 0x40 in the following cycle reads index 1 (untrained), still 0. Directly checking PHT[0]=2'b10 confirms the write.
- Async reset pulled low between edges mid-training -> pred_valid, counters and tables clear without a clock edge. After release, the reset-state lookup result repeats.

Source files
------------

// File: rtl/pshare_pkg.sv
// Shared types, constants and helpers for the pshare branch predictor.
// Counter arithmetic and index hashing live here so top and array agree.
package pshare_pkg;

    typedef enum logic [1:0] {
        SN = 2'b00,
        WN = 2'b01,
        WT = 2'b10,
        ST = 2'b11
    } ctr2_e;

    localparam logic [1:0] CTR2_RST = WN;

    function automatic logic [31:0] ctr_rst_val(input int w);
        return (32'h1 << (w - 1)) - 32'h1;
    endfunction

    function automatic logic [31:0] sat_upd(
        input logic [31:0] c,
        input logic        inc,
        input int          w
    );
        logic [31:0] max;
        max = (32'h1 << w) - 32'h1;
        if (inc)
            return (c == max) ? c : c + 32'h1;
        return (c == 32'h0) ? c : c - 32'h1;
    endfunction

    function automatic logic [31:0] bht_index(
        input logic [31:0] pc,
        input int          bits
    );
        return (pc >> 2) & ((32'h1 << bits) - 32'h1);
    endfunction

    function automatic logic [31:0] pht_index(
        input logic [31:0] pc,
        input logic [31:0] hist,
        input int          hw
    );
        return ((pc >> 2) ^ hist) & ((32'h1 << hw) - 32'h1);
    endfunction

endpackage

// File: rtl/pshare_ctr_array.sv
// Pattern history table: saturating counters with one combinational
// read port and one read-modify-write training port.
module pshare_ctr_array
    import pshare_pkg::*;
#(
    parameter int HIST_W = 4,
    parameter int CTR_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [HIST_W-1:0] i_rd_idx,
    output logic [CTR_W-1:0]  o_rd_ctr,
    input  logic              i_wr_en,
    input  logic [HIST_W-1:0] i_wr_idx,
    input  logic              i_wr_taken
);

    localparam int N = 1 << HIST_W;
    localparam logic [31:0] RST32 = ctr_rst_val(CTR_W);
    localparam logic [CTR_W-1:0] CTR_RST = RST32[CTR_W-1:0];

    logic [CTR_W-1:0] r_ctr [N];
    logic [CTR_W-1:0] w_cur;
    logic [31:0]      w_sat;
    logic [CTR_W-1:0] w_next;

    assign o_rd_ctr = r_ctr[i_rd_idx];
    assign w_cur    = r_ctr[i_wr_idx];
    assign w_sat    = sat_upd(32'(w_cur), i_wr_taken, CTR_W);
    assign w_next   = w_sat[CTR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++)
                r_ctr[i] <= CTR_RST;
        end else if (i_wr_en) begin
            r_ctr[i_wr_idx] <= w_next;
        end
    end

endmodule

// File: rtl/pshare_predictor.sv
// Local-history (pshare) direction and target predictor with
// registered lookup, same-edge training and wrapping statistics.
module pshare_predictor
    import pshare_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int BHT_BITS = 4,
    parameter int HIST_W   = 4,
    parameter int CTR_W    = 2,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lookup_valid,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    output logic [CNT_W-1:0]  total_branch,
    output logic [CNT_W-1:0]  mispredicts
);

    localparam int NB = 1 << BHT_BITS;

    logic [HIST_W-1:0] r_bht   [NB];
    logic [ADDR_W-1:0] r_tgt   [NB];
    logic              r_tgt_v [NB];

    logic              r_pred_valid;
    logic              r_pred_taken;
    logic [ADDR_W-1:0] r_pred_target;
    logic [CNT_W-1:0]  r_total;
    logic [CNT_W-1:0]  r_mis;

    logic [31:0]         w_lk_b32;
    logic [31:0]         w_lk_p32;
    logic [31:0]         w_up_b32;
    logic [31:0]         w_up_p32;
    logic [BHT_BITS-1:0] w_lk_bidx;
    logic [HIST_W-1:0]   w_lk_pidx;
    logic [BHT_BITS-1:0] w_up_bidx;
    logic [HIST_W-1:0]   w_up_pidx;
    logic [CTR_W-1:0]    w_rd_ctr;
    logic                w_lk_taken;
    logic [ADDR_W-1:0]   w_lk_target;
    logic [HIST_W-1:0]   w_up_hist;

    assign w_lk_b32  = bht_index(32'(lookup_pc), BHT_BITS);
    assign w_lk_bidx = w_lk_b32[BHT_BITS-1:0];
    assign w_lk_p32  = pht_index(32'(lookup_pc),
                                 32'(r_bht[w_lk_bidx]), HIST_W);
    assign w_lk_pidx = w_lk_p32[HIST_W-1:0];

    assign w_up_b32  = bht_index(32'(upd_pc), BHT_BITS);
    assign w_up_bidx = w_up_b32[BHT_BITS-1:0];
    assign w_up_hist = r_bht[w_up_bidx];
    assign w_up_p32  = pht_index(32'(upd_pc), 32'(w_up_hist), HIST_W);
    assign w_up_pidx = w_up_p32[HIST_W-1:0];

    pshare_ctr_array #(
        .HIST_W (HIST_W),
        .CTR_W  (CTR_W)
    ) u_ctr (
        .clk        (clk),
        .rst_n      (reset),
        .i_rd_idx   (w_lk_pidx),
        .o_rd_ctr   (w_rd_ctr),
        .i_wr_en    (upd_valid),
        .i_wr_idx   (w_up_pidx),
        .i_wr_taken (upd_taken)
    );

    assign w_lk_taken  = w_rd_ctr[CTR_W-1];
    // Fall through when not taken or no trained target exists yet.
    assign w_lk_target = (w_lk_taken && r_tgt_v[w_lk_bidx])
                       ? r_tgt[w_lk_bidx]
                       : lookup_pc + ADDR_W'(4);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pred_valid  <= 1'b0;
            r_pred_taken  <= 1'b0;
            r_pred_target <= '0;
        end else begin
            r_pred_valid <= lookup_valid;
            if (lookup_valid) begin
                r_pred_taken  <= w_lk_taken;
                r_pred_target <= w_lk_target;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NB; i++) begin
                r_bht[i]   <= '0;
                r_tgt[i]   <= '0;
                r_tgt_v[i] <= 1'b0;
            end
        end else if (upd_valid) begin
            r_bht[w_up_bidx] <= {w_up_hist[HIST_W-2:0], upd_taken};
            if (upd_taken) begin
                r_tgt[w_up_bidx]   <= upd_target;
                r_tgt_v[w_up_bidx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_total <= '0;
            r_mis   <= '0;
        end else if (upd_valid) begin
            r_total <= r_total + CNT_W'(1);
            if (upd_taken != upd_pred_taken)
                r_mis <= r_mis + CNT_W'(1);
        end
    end

    assign pred_valid   = r_pred_valid;
    assign pred_taken   = r_pred_taken;
    assign pred_target  = r_pred_target;
    assign total_branch = r_total;
    assign mispredicts  = r_mis;

endmodule

// File: tb/tb_pshare_predictor.sv
// Scoreboard bench for pshare_predictor, with a narrow-counter
// second instance to exercise statistics wrap-around.
module tb_pshare_predictor;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_pred_taken = 1'b0;
    logic [31:0] total_branch;
    logic [31:0] mispredicts;

    logic        s_upd_valid = 1'b0;
    logic        s_upd_taken = 1'b0;
    logic        s_pred_valid;
    logic        s_pred_taken;
    logic [31:0] s_pred_target;
    logic [3:0]  s_total;
    logic [3:0]  s_mis;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0]  m_bht [16];
    logic [1:0]  m_pht [16];
    logic [31:0] m_tgt [16];
    logic        m_tv  [16];
    logic [31:0] m_tot;
    logic [31:0] m_mis;
    logic        exp_v;
    logic [32:0] sb_q [$];

    always #5 clk = ~clk;

    pshare_predictor dut (
        .clk            (clk),
        .reset          (reset),
        .lookup_valid   (lookup_valid),
        .lookup_pc      (lookup_pc),
        .pred_valid     (pred_valid),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_pred_taken (upd_pred_taken),
        .total_branch   (total_branch),
        .mispredicts    (mispredicts)
    );

    pshare_predictor #(.CNT_W(4)) dut_s (
        .clk            (clk),
        .reset          (reset),
        .lookup_valid   (1'b0),
        .lookup_pc      (32'h0),
        .pred_valid     (s_pred_valid),
        .pred_taken     (s_pred_taken),
        .pred_target    (s_pred_target),
        .upd_valid      (s_upd_valid),
        .upd_pc         (32'h40),
        .upd_taken      (s_upd_taken),
        .upd_target     (32'h80),
        .upd_pred_taken (1'b1),
        .total_branch   (s_total),
        .mispredicts    (s_mis)
    );

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_bht[i] = '0;
            m_pht[i] = 2'b01;
            m_tgt[i] = '0;
            m_tv[i]  = 1'b0;
        end
        m_tot = '0;
        m_mis = '0;
        exp_v = 1'b0;
        sb_q.delete();
    endtask

    task automatic tick();
        logic [32:0] e;
        @(posedge clk);
        #1;
        n_checks++;
        if (pred_valid !== exp_v) begin
            n_fail++;
            $display("FAIL pred_valid: got %b want %b", pred_valid, exp_v);
        end
        if (pred_valid === 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_empty: got prediction, none expected");
            end else begin
                e = sb_q.pop_front();
                if ({pred_taken, pred_target} !== e) begin
                    n_fail++;
                    $display("FAIL pred: got %b/%h want %b/%h",
                             pred_taken, pred_target, e[32], e[31:0]);
                end
            end
        end
        n_checks++;
        if (total_branch !== m_tot || mispredicts !== m_mis) begin
            n_fail++;
            $display("FAIL stats: got %0d/%0d want %0d/%0d",
                     total_branch, mispredicts, m_tot, m_mis);
        end
    endtask

    task automatic cyc(
        input logic        lv,
        input logic [31:0] lpc,
        input logic        uv,
        input logic [31:0] upc,
        input logic        ut,
        input logic [31:0] utg,
        input logic        upt
    );
        logic [3:0] b;
        logic [3:0] p;
        logic       tk;
        lookup_valid   = lv;
        lookup_pc      = lpc;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_taken      = ut;
        upd_target     = utg;
        upd_pred_taken = upt;
        if (lv) begin
            b  = lpc[5:2];
            p  = lpc[5:2] ^ m_bht[b];
            tk = m_pht[p][1];
            sb_q.push_back({tk, (tk && m_tv[b]) ? m_tgt[b] : lpc + 32'd4});
        end
        exp_v = lv;
        if (uv) begin
            b = upc[5:2];
            p = upc[5:2] ^ m_bht[b];
            if (ut && m_pht[p] != 2'b11) m_pht[p] = m_pht[p] + 2'd1;
            if (!ut && m_pht[p] != 2'b00) m_pht[p] = m_pht[p] - 2'd1;
            m_bht[b] = {m_bht[b][2:0], ut};
            if (ut) begin
                m_tgt[b] = utg;
                m_tv[b]  = 1'b1;
            end
            m_tot = m_tot + 32'd1;
            if (ut != upt) m_mis = m_mis + 32'd1;
        end
        tick();
        lookup_valid = 1'b0;
        upd_valid    = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (pred_valid !== 1'b0 || pred_target !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_out: got %b/%h want 0/0",
                     pred_valid, pred_target);
        end
        cyc(1, 32'h100, 0, 0, 0, 0, 0);
        n_checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            n_fail++;
            $display("FAIL reset_lookup: got %b/%h want 0/104",
                     pred_taken, pred_target);
        end
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_train();
        for (int i = 0; i < 5; i++)
            cyc(0, 0, 1, 32'h40, 1, 32'h80, 0);
        n_checks++;
        if (dut.r_bht[0] !== 4'b1111) begin
            n_fail++;
            $display("FAIL train_hist: got %b want 1111", dut.r_bht[0]);
        end
        cyc(1, 32'h40, 0, 0, 0, 0, 0);
        n_checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
            n_fail++;
            $display("FAIL train_pred: got %b/%h want 1/80",
                     pred_taken, pred_target);
        end
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 1, 32'h40, 1, 32'h80, 1);
        n_checks++;
        if (dut.u_ctr.r_ctr[15] !== 2'b11) begin
            n_fail++;
            $display("FAIL sat_hi: got %b want 11", dut.u_ctr.r_ctr[15]);
        end
        cyc(0, 0, 1, 32'h40, 0, 32'h0, 1);
        n_checks++;
        if (dut.u_ctr.r_ctr[15] !== 2'b10 || dut.r_bht[0] !== 4'b1110) begin
            n_fail++;
            $display("FAIL sat_dec: got %b/%b want 10/1110",
                     dut.u_ctr.r_ctr[15], dut.r_bht[0]);
        end
        cyc(1, 32'h40, 0, 0, 0, 0, 0);
        n_checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h44) begin
            n_fail++;
            $display("FAIL sat_pred: got %b/%h want 0/44",
                     pred_taken, pred_target);
        end
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_stats();
        logic [31:0] t0;
        logic [31:0] m0;
        t0 = total_branch;
        m0 = mispredicts;
        cyc(0, 0, 1, 32'h200, 0, 0, 1);
        n_checks++;
        if (total_branch !== t0 + 1 || mispredicts !== m0 + 1) begin
            n_fail++;
            $display("FAIL stats_mis: got %0d/%0d want %0d/%0d",
                     total_branch, mispredicts, t0 + 1, m0 + 1);
        end
        cyc(0, 0, 1, 32'h200, 1, 32'h300, 1);
        n_checks++;
        if (total_branch !== t0 + 2 || mispredicts !== m0 + 1) begin
            n_fail++;
            $display("FAIL stats_hit: got %0d/%0d want %0d/%0d",
                     total_branch, mispredicts, t0 + 2, m0 + 1);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        s_upd_valid = 1'b1;
        s_upd_taken = 1'b0;
        for (int i = 0; i < 15; i++) @(posedge clk);
        #1;
        n_checks++;
        if (s_total !== 4'd15 || s_mis !== 4'd15) begin
            n_fail++;
            $display("FAIL wrap_max: got %0d/%0d want 15/15", s_total, s_mis);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (s_total !== 4'd0 || s_mis !== 4'd0) begin
            n_fail++;
            $display("FAIL wrap_zero: got %0d/%0d want 0/0", s_total, s_mis);
        end
        s_upd_taken = 1'b1;
        @(posedge clk);
        #1;
        s_upd_valid = 1'b0;
        n_checks++;
        if (s_total !== 4'd1 || s_mis !== 4'd0) begin
            n_fail++;
            $display("FAIL wrap_next: got %0d/%0d want 1/0", s_total, s_mis);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cyc(1, 32'h40, 1, 32'h40, 1, 32'h80, 0);
        n_checks++;
        if (pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_same: got %b want 0", pred_taken);
        end
        cyc(1, 32'h40, 0, 0, 0, 0, 0);
        n_checks++;
        if (pred_taken !== 1'b0 || dut.u_ctr.r_ctr[0] !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_next: got %b/%b want 0/10",
                     pred_taken, dut.u_ctr.r_ctr[0]);
        end
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++)
            cyc(i == 3, 32'h40, 1, 32'h40, 1, 32'h80, 1);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (pred_valid !== 1'b0 || total_branch !== 32'd0 ||
            mispredicts !== 32'd0 || dut.r_bht[0] !== 4'd0 ||
            dut.u_ctr.r_ctr[7] !== 2'b01 || dut.r_tgt_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst: got v=%b tot=%0d h=%b c=%b tv=%b",
                     pred_valid, total_branch, dut.r_bht[0],
                     dut.u_ctr.r_ctr[7], dut.r_tgt_v[0]);
        end
        do_reset();
        cyc(1, 32'h100, 0, 0, 0, 0, 0);
        n_checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            n_fail++;
            $display("FAIL async_after: got %b/%h want 0/104",
                     pred_taken, pred_target);
        end
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_train();
        test_saturate();
        test_stats();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
